// File: rtl/package_feed_arbiter.sv
// package_feed_arbiter
//   Arbitrates up to four loading stations onto the single weight input of
//   the package sorter. Each accepted nonzero package is driven for
//   HOLD_CYCLES cycles, followed by GAP_CYCLES cycles of zero weight and at
//   least one IDLE cycle. Zero-weight requests are acked and counted as drops.
//
//   Build option: FEED_FIXED_PRIORITY_EN
//     defined   -> fixed priority, station 0 highest, no round-robin pointer
//     undefined -> round-robin starting at the pointer (default)
//
// Ports:
//   CLK            in   1   system clock, rising edge
//   Reset          in   1   synchronous, active-high reset
//   req            in   4   per-station request
//   weight_in      in  48   station weights, [12i+11:12i] = station i
//   ack            out  4   one-cycle accept pulse per station
//   grant          out  4   one-hot owner of weight_out
//   weight_out     out 12   weight to sorter, 0 when no package presented
//   busy           out  1   high whenever the state is not IDLE
//   dispatch_count out  8   packages presented, modulo 256
//   drop_count     out  8   zero-weight requests discarded, modulo 256
module package_feed_arbiter #(
   parameter int unsigned NUM_STATIONS = 4,
   parameter int unsigned HOLD_CYCLES  = 3,
   parameter int unsigned GAP_CYCLES   = 2
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic [NUM_STATIONS-1:0]    req,
   input  logic [12*NUM_STATIONS-1:0] weight_in,
   output logic [NUM_STATIONS-1:0]    ack,
   output logic [NUM_STATIONS-1:0]    grant,
   output logic [11:0]                weight_out,
   output logic                       busy,
   output logic [7:0]                 dispatch_count,
   output logic [7:0]                 drop_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

   localparam logic [NUM_STATIONS-1:0] ONE_HOT0 = NUM_STATIONS'(1);

   state_t                  r_state, w_state_nxt;
   logic [3:0]              r_timer, w_timer_nxt;
   logic [NUM_STATIONS-1:0] r_ack, w_ack_nxt;
   logic [NUM_STATIONS-1:0] r_grant, w_grant_nxt;
   logic [11:0]             r_wout, w_wout_nxt;
   logic [7:0]              r_disp, w_disp_nxt;
   logic [7:0]              r_drop, w_drop_nxt;
`ifndef FEED_FIXED_PRIORITY_EN
   logic [1:0]              r_ptr, w_ptr_nxt;
`endif

   logic                    w_found;
   logic [1:0]              w_sel;
   logic [1:0]              w_idx;
   logic [11:0]             w_sel_weight;

   // Winner search: first requester scanning upward from the start index.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NUM_STATIONS; k++) begin
`ifdef FEED_FIXED_PRIORITY_EN
         w_idx = 2'(k);
`else
         w_idx = r_ptr + 2'(k);
`endif
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   assign w_sel_weight = weight_in[12*w_sel +: 12];

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_ack_nxt   = '0;
      w_grant_nxt = r_grant;
      w_wout_nxt  = r_wout;
      w_disp_nxt  = r_disp;
      w_drop_nxt  = r_drop;
`ifndef FEED_FIXED_PRIORITY_EN
      w_ptr_nxt   = r_ptr;
`endif
      case (r_state)
         ST_IDLE: begin
            w_grant_nxt = '0;
            w_wout_nxt  = '0;
            if (w_found) begin
               w_ack_nxt = ONE_HOT0 << w_sel;
`ifndef FEED_FIXED_PRIORITY_EN
               w_ptr_nxt = w_sel + 2'd1;
`endif
               if (w_sel_weight != '0) begin
                  w_grant_nxt = ONE_HOT0 << w_sel;
                  w_wout_nxt  = w_sel_weight;
                  w_timer_nxt = 4'(HOLD_CYCLES - 1);
                  w_state_nxt = ST_HOLD;
                  w_disp_nxt  = r_disp + 8'd1;
               end else begin
                  // Zero weight: ack and discard without leaving IDLE.
                  w_drop_nxt = r_drop + 8'd1;
               end
            end
         end
         ST_HOLD: begin
            if (r_timer == '0) begin
               w_grant_nxt = '0;
               w_wout_nxt  = '0;
               w_timer_nxt = 4'(GAP_CYCLES - 1);
               w_state_nxt = ST_GAP;
            end else begin
               w_timer_nxt = r_timer - 4'd1;
            end
         end
         ST_GAP: begin
            w_wout_nxt = '0;
            if (r_timer == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_timer_nxt = r_timer - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_wout_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_ack   <= '0;
         r_grant <= '0;
         r_wout  <= '0;
         r_disp  <= '0;
         r_drop  <= '0;
`ifndef FEED_FIXED_PRIORITY_EN
         r_ptr   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_ack   <= w_ack_nxt;
         r_grant <= w_grant_nxt;
         r_wout  <= w_wout_nxt;
         r_disp  <= w_disp_nxt;
         r_drop  <= w_drop_nxt;
`ifndef FEED_FIXED_PRIORITY_EN
         r_ptr   <= w_ptr_nxt;
`endif
      end
   end

   assign ack            = r_ack;
   assign grant          = r_grant;
   assign weight_out     = r_wout;
   assign busy           = (r_state != ST_IDLE);
   assign dispatch_count = r_disp;
   assign drop_count     = r_drop;

endmodule
